register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/rf_pkg.sv | 16 +
 rtl/register_file.sv | 87 ++++++++
 tb/tb_register_file.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the 16x16 register file.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rf_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // Two-state controller: normal operation, or sequential zeroing of the array.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/register_file.sv
// 16x16 register file with two registered read ports, one write port, and a sequential clear.
// Latency: 1 cycle read (write-first bypass on address match); clear takes 16 cycles.
// Backpressure: Busy high during clear; writes, reads and Clr are ignored and read data holds.
module register_file
  import rf_pkg::*;
(
  input  logic                Clk,
  input  logic                ResetN,
  input  logic [DATA_W-1:0]   W_data,
  input  logic [ADDR_W-1:0]   W_addr,
  input  logic                W_wr,
  input  logic [ADDR_W-1:0]   Ra_addr,
  input  logic                Ra_rd,
  input  logic [ADDR_W-1:0]   Rb_addr,
  input  logic                Rb_rd,
  input  logic                Clr,
  output logic [DATA_W-1:0]   Ra_data,
  output logic [DATA_W-1:0]   Rb_data,
  output logic                Busy
);

  rf_state_t             state;
  logic [ADDR_W-1:0]     clr_ptr;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic idle;
  logic wr_en;
  logic ra_en;
  logic rb_en;
  logic ra_hit;
  logic rb_hit;

  // A Clr request in the same IDLE cycle as a write wins and drops the write.
  assign idle   = (state == IDLE);
  assign wr_en  = idle && W_wr && !Clr;
  assign ra_en  = idle && Ra_rd;
  assign rb_en  = idle && Rb_rd;
  assign ra_hit = wr_en && (W_addr == Ra_addr);
  assign rb_hit = wr_en && (W_addr == Rb_addr);
  assign Busy   = (state == CLEAR);

  // Array update: clear pointer owns the write port while clearing; no reset on the storage.
  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      mem[W_addr] <= W_data;
    end
  end

  // Controller and read registers: reset starts a full clear from entry 0.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      Ra_data <= '0;
      Rb_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
          if (ra_en) begin
            Ra_data <= ra_hit ? W_data : mem[Ra_addr];
          end
          if (rb_en) begin
            Rb_data <= rb_hit ? W_data : mem[Rb_addr];
          end
        end
        CLEAR: begin
          // Single pass only: the last entry returns to IDLE instead of wrapping.
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with an expected-read-data scoreboard.
// Latency: expectations pushed when a read is driven, popped one edge later.
// Backpressure: clear windows measured in edges with a bounded wait.
module tb_register_file;
  import rf_pkg::*;

  logic              Clk;
  logic              ResetN;
  logic [DATA_W-1:0] W_data;
  logic [ADDR_W-1:0] W_addr;
  logic              W_wr;
  logic [ADDR_W-1:0] Ra_addr;
  logic              Ra_rd;
  logic [ADDR_W-1:0] Rb_addr;
  logic              Rb_rd;
  logic              Clr;
  logic [DATA_W-1:0] Ra_data;
  logic [DATA_W-1:0] Rb_data;
  logic              Busy;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] qa [$];
  logic [DATA_W-1:0] qb [$];

  register_file dut (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .W_data  (W_data),
    .W_addr  (W_addr),
    .W_wr    (W_wr),
    .Ra_addr (Ra_addr),
    .Ra_rd   (Ra_rd),
    .Rb_addr (Rb_addr),
    .Rb_rd   (Rb_rd),
    .Clr     (Clr),
    .Ra_data (Ra_data),
    .Rb_data (Rb_data),
    .Busy    (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Pop and compare whatever read results were scheduled for this edge.
  task automatic check_q(input string tag);
    logic [DATA_W-1:0] v;
    if (qa.size() > 0) begin
      v = qa.pop_front();
      chk({tag, "_a"}, 32'(Ra_data), 32'(v));
    end
    if (qb.size() > 0) begin
      v = qb.pop_front();
      chk({tag, "_b"}, 32'(Rb_data), 32'(v));
    end
  endtask

  task automatic idle_inputs();
    W_wr  = 1'b0;
    Ra_rd = 1'b0;
    Rb_rd = 1'b0;
    Clr   = 1'b0;
  endtask

  // Count edges until Busy drops, bounded so a stuck clear is reported, not hung on.
  task automatic wait_clear(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic read2(input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] ea, input logic [15:0] eb, input string tag);
    Ra_addr = a; Rb_addr = b; Ra_rd = 1'b1; Rb_rd = 1'b1;
    qa.push_back(ea);
    qb.push_back(eb);
    tick();
    idle_inputs();
    check_q(tag);
  endtask

  task automatic write1(input logic [3:0] a, input logic [15:0] d);
    W_addr = a; W_data = d; W_wr = 1'b1;
    tick();
    W_wr = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] held_a;
    logic [15:0] held_b;

    ResetN = 1'b0;
    W_data = '0; W_addr = '0; Ra_addr = '0; Rb_addr = '0;
    idle_inputs();

    // Reset state
    #12;
    chk("rst_ra", 32'(Ra_data), 32'h0);
    chk("rst_rb", 32'(Rb_data), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h1);
    ResetN = 1'b1;

    // Post-reset clear: 16 edges of Busy, then every entry reads zero
    wait_clear(n);
    chk("rst_clear_len", 32'(n), 32'd16);
    chk("rst_busy_low", 32'(Busy), 32'h0);
    for (int i = 0; i < 16; i++) begin
      read2(4'(i), 4'(15 - i), 16'h0000, 16'h0000, "init_zero");
    end

    // Write then read next cycle
    write1(4'd5, 16'hBEEF);
    Ra_addr = 4'd5; Ra_rd = 1'b1;
    qa.push_back(16'hBEEF);
    tick();
    idle_inputs();
    check_q("wr_then_rd");
    chk("rb_hold", 32'(Rb_data), 32'h0);

    // Same-cycle write and both-port read: write-first bypass
    W_addr = 4'd3; W_data = 16'h1234; W_wr = 1'b1;
    Ra_addr = 4'd3; Rb_addr = 4'd3; Ra_rd = 1'b1; Rb_rd = 1'b1;
    qa.push_back(16'h1234);
    qb.push_back(16'h1234);
    tick();
    idle_inputs();
    check_q("bypass_both");
    read2(4'd5, 4'd3, 16'hBEEF, 16'h1234, "stored_after_bypass");

    // Bypass is per port: only A matches the write address
    W_addr = 4'd4; W_data = 16'h4444; W_wr = 1'b1;
    Ra_addr = 4'd4; Rb_addr = 4'd5; Ra_rd = 1'b1; Rb_rd = 1'b1;
    qa.push_back(16'h4444);
    qb.push_back(16'hBEEF);
    tick();
    idle_inputs();
    check_q("bypass_a_only");

    // Read disabled: outputs hold
    Ra_addr = 4'd3; Rb_addr = 4'd3;
    tick();
    chk("hold_ra", 32'(Ra_data), 32'h4444);
    chk("hold_rb", 32'(Rb_data), 32'hBEEF);

    // Clr beats a simultaneous write; clear zeros both the old and the dropped entry
    write1(4'd7, 16'hA5A5);
    read2(4'd7, 4'd7, 16'hA5A5, 16'hA5A5, "fill7");
    W_addr = 4'd2; W_data = 16'hFFFF; W_wr = 1'b1; Clr = 1'b1;
    tick();
    idle_inputs();
    chk("clr_busy", 32'(Busy), 32'h1);
    wait_clear(n);
    chk("clr_len", 32'(n), 32'd16);
    chk("clr_hold_ra", 32'(Ra_data), 32'hA5A5);
    read2(4'd2, 4'd7, 16'h0000, 16'h0000, "after_clr");
    read2(4'd5, 4'd3, 16'h0000, 16'h0000, "after_clr2");

    // During clear: write dropped, Clr ignored, reads ignored
    read2(4'd4, 4'd4, 16'h0000, 16'h0000, "pre_clr2");
    write1(4'd9, 16'h9999);
    read2(4'd9, 4'd9, 16'h9999, 16'h9999, "fill9");
    held_a = Ra_data;
    held_b = Rb_data;
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    W_addr = 4'd9; W_data = 16'h5555; W_wr = 1'b1; Clr = 1'b1;
    Ra_addr = 4'd9; Ra_rd = 1'b1; Rb_addr = 4'd1; Rb_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_hold_ra", 32'(Ra_data), 32'(held_a));
      chk("busy_hold_rb", 32'(Rb_data), 32'(held_b));
    end
    idle_inputs();
    wait_clear(n);
    chk("no_restart_len", 32'(14 + n), 32'd16);
    read2(4'd9, 4'd9, 16'h0000, 16'h0000, "dropped_wr9");

    // Reset in the middle of a clear
    write1(4'd1, 16'h1111);
    read2(4'd1, 4'd1, 16'h1111, 16'h1111, "fill1");
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    ResetN = 1'b0;
    #1;
    chk("midrst_ra", 32'(Ra_data), 32'h0);
    chk("midrst_rb", 32'(Rb_data), 32'h0);
    chk("midrst_busy", 32'(Busy), 32'h1);
    tick();
    ResetN = 1'b1;
    wait_clear(n);
    chk("midrst_len", 32'(n), 32'd16);
    read2(4'd1, 4'd15, 16'h0000, 16'h0000, "midrst_zero");

    chk("queues_drained", 32'(qa.size() + qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
